// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU among num_req_p requesters.
// Opcode encoding lives in alu_pkg; unlisted opcodes produce a zero result.
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
endpackage

module alu #(
    parameter int width_p = 32
) (
    input  logic [3:0]         op_i,
    input  logic [width_p-1:0] d1_i,
    input  logic [width_p-1:0] d2_i,
    output logic [width_p-1:0] result_o,
    output logic               zero_o,
    output logic               sign_o
);
    import alu_pkg::*;

    localparam int sh_w = $clog2(width_p);

    logic [sh_w-1:0] shamt;
    logic            lt_s;
    logic            lt_u;

    assign shamt = d2_i[sh_w-1:0];
    assign lt_s  = $signed(d1_i) < $signed(d2_i);
    assign lt_u  = d1_i < d2_i;

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = d1_i + d2_i;
            OP_SUB:  result_o = d1_i - d2_i;
            OP_AND:  result_o = d1_i & d2_i;
            OP_OR:   result_o = d1_i | d2_i;
            OP_XOR:  result_o = d1_i ^ d2_i;
            OP_SLL:  result_o = d1_i << shamt;
            OP_SRL:  result_o = d1_i >> shamt;
            OP_SRA:  result_o = $unsigned($signed(d1_i) >>> shamt);
            OP_SLT:  result_o = {{(width_p-1){1'b0}}, lt_s};
            OP_SLTU: result_o = {{(width_p-1){1'b0}}, lt_u};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);
    assign sign_o = result_o[width_p-1];
endmodule

// State table:
//   IDLE | granting: one requester sees req_ready_o, operands captured on accept
//   RESP | ALU runs on captured operands, result offered to the owner only
module alu_arbiter #(
    parameter int width_p   = 32,
    parameter int num_req_p = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [num_req_p-1:0]              req_valid_i,
    output logic [num_req_p-1:0]              req_ready_o,
    input  logic [num_req_p-1:0][width_p-1:0] req_d1_i,
    input  logic [num_req_p-1:0][width_p-1:0] req_d2_i,
    input  logic [num_req_p-1:0][3:0]         req_op_i,
    output logic [num_req_p-1:0]              rsp_valid_o,
    input  logic [num_req_p-1:0]              rsp_ready_i,
    output logic [width_p-1:0]                rsp_result_o,
    output logic                              rsp_zero_o,
    output logic                              rsp_sign_o,
    output logic                              busy_o
);
    localparam int idx_w = $clog2(num_req_p);

    typedef enum logic {IDLE, RESP} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [idx_w-1:0]   last_q;
    logic [idx_w-1:0]   owner_q;
    logic [idx_w-1:0]   grant_idx;
    logic [idx_w-1:0]   cand;
    logic               grant_any;
    logic               accept;
    logic               rsp_ack;
    logic [width_p-1:0] d1_q;
    logic [width_p-1:0] d2_q;
    logic [3:0]         op_q;

    // Rotating search starting just after the last winner; wraps at num_req_p,
    // so non-power-of-2 counts never produce an out-of-range index.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = last_q;
        for (int i = 0; i < num_req_p; i++) begin
            cand = (cand == idx_w'(num_req_p - 1)) ? '0 : cand + 1'b1;
            if (!grant_any && req_valid_i[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept  = (state_q == IDLE) && grant_any;
    assign rsp_ack = rsp_ready_i[owner_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = RESP;
            RESP:    if (rsp_ack)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) req_ready_o[grant_idx] = 1'b1;
            end
            RESP: begin
                rsp_valid_o[owner_q] = 1'b1;
                busy_o               = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand registers feed the ALU directly; they also hold the last
    // operation in IDLE so the result outputs stay quiet between requests.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q  <= idx_w'(num_req_p - 1);
            owner_q <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            op_q    <= '0;
        end else if (accept) begin
            last_q  <= grant_idx;
            owner_q <= grant_idx;
            d1_q    <= req_d1_i[grant_idx];
            d2_q    <= req_d2_i[grant_idx];
            op_q    <= req_op_i[grant_idx];
        end
    end

    alu #(
        .width_p (width_p)
    ) u_alu (
        .op_i     (op_q),
        .d1_i     (d1_q),
        .d2_i     (d2_q),
        .result_o (rsp_result_o),
        .zero_o   (rsp_zero_o),
        .sign_o   (rsp_sign_o)
    );

    for (genvar i = 0; i < num_req_p; i++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (req_valid_i[i] && !req_ready_o[i]) |=>
                (req_valid_i[i] && $stable(req_d1_i[i]) &&
                 $stable(req_d2_i[i]) && $stable(req_op_i[i])));
    end

    a_one_grant: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));
    a_one_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(rsp_valid_o));
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance among `num_req_p` requesters using round-robin arbitration and valid/ready handshakes. Operands, opcode and requester index are captured at acceptance, and the result is held until the owning requester accepts it. Typical requesters are the execute stage, the branch-target adder and the load/store address generator.

## Interface
- `width_p`, 32: datapath width; passed to the internal `alu`.
- `num_req_p`, 2: number of requesters; legal range 2..4.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  num_req_p  request valid, one bit per requester.
- `req_ready_o`  out  num_req_p  request accepted; at most one bit high (grant).
- `req_d1_i`  in  num_req_p x width_p  operand 1 per requester.
- `req_d2_i`  in  num_req_p x width_p  operand 2 per requester.
- `req_op_i`  in  num_req_p x 4  ALU opcode per requester (alu_pkg encoding).
- `rsp_valid_o`  out  num_req_p  response valid; only the owner's bit is high.
- `rsp_ready_i`  in  num_req_p  response accept, one bit per requester.
- `rsp_result_o`  out  width_p  ALU result, shared by all requesters.
- `rsp_zero_o`  out  1  result == 0.
- `rsp_sign_o`  out  1  result MSB.
- `busy_o`  out  1  high while a response is outstanding.

## Operation
- FSM with two states, IDLE and RESP.
- **IDLE:**
  - Grant goes to the first requester with `req_valid_i` set, searching upward from `(last_q+1) mod num_req_p` and wrapping.
  - `req_ready_o[g]` = 1 for the granted requester only. This is combinational from `req_valid_i` and `last_q`.
  - If any valid is set, on the clock edge: capture `d1`, `d2` and `op` of `g` into operand registers; set `owner_q = g` and `last_q = g`; go to RESP.
  - If no valid is set, stay in IDLE and leave `last_q` unchanged.
- **RESP:**
  - `req_ready_o` = 0.
  - The `alu` is driven from the operand registers.
  - `rsp_valid_o[owner_q]` = 1; all other bits are 0.
  - `rsp_result_o`, `rsp_zero_o` and `rsp_sign_o` come straight from the `alu` outputs and stay stable while in RESP.
  - When `rsp_ready_i[owner_q]` = 1, go to IDLE. `rsp_ready_i` bits of non-owners are ignored.
- In IDLE, `rsp_valid_o` = 0. `rsp_result_o`, `rsp_zero_o` and `rsp_sign_o` are don't-care; the implementation holds the last captured operation.
- `busy_o` = (state == RESP).
- Opcodes are not checked. An undefined opcode yields result 0 (zero = 1, sign = 0) and completes normally.
- Widths:
  - Owner and last-grant registers are `$clog2(num_req_p)` bits.
  - Wrap-around follows the modulo rule above for non-power-of-2 `num_req_p`; index `num_req_p` is never produced.
- Requester obligations (enforced by assertion, not by logic):
  - Once valid, hold `valid`, `d1`, `d2` and `op` stable until ready.
  - Do not withdraw `rsp_ready` semantics.

## Timing
- Reset values:
  - state = IDLE; `last_q = num_req_p-1`, so requester 0 wins first; `owner_q = 0`; operand registers = 0.
  - Outputs: `req_ready_o` follows grant logic (0 when no valid); `rsp_valid_o` = 0; `busy_o` = 0; `rsp_result_o` = 0, `rsp_zero_o` = 1, `rsp_sign_o` = 0 (ADD of zeros).
- Latency: request accepted at edge N gives `rsp_valid_o` high during cycle N+1, i.e. one cycle.
- Throughput: at most one operation per 2 cycles. IDLE is always re-entered after a response, so there is no same-cycle accept on response handshake and no combinational path from `rsp_ready_i` to `req_ready_o`.
- Response backpressure: RESP holds indefinitely while `rsp_ready_i[owner_q]` = 0, and no new request is granted.
- Simultaneous requests:
  - Exactly one grant per accept.
  - A requester that keeps `valid` high is served within `num_req_p` accepts (no starvation).
- Reset asserted mid-RESP:
  - Outstanding response is discarded and outputs take reset values immediately (asynchronous).
  - First grant after release goes to requester 0.

## Test plan
- **Reset values:** assert `rst_i` mid-RESP for 1 cycle -> `rsp_valid_o` = 0 and `busy_o` = 0 immediately; after release, requesters 0 and 1 valid together -> `req_ready_o` = 2'b01.
- **Single request:** req1 with ADD 5+7 -> `req_ready_o` = 2'b10; next cycle `rsp_valid_o` = 2'b10, result 12, zero 0, sign 0; `rsp_ready_i` = 2'b10 -> IDLE the following cycle.
- **Round-robin:** both requesters hold valid continuously with `rsp_ready_i` = 2'b11 -> grant order 0,1,0,1 with accepts every 2 cycles; SUB 3-3 from req0 gives zero = 1.
- **Backpressure:** req0 issues SRA 0x80000000 >> 4, `rsp_ready_i` = 0 for 5 cycles -> result holds 0xF8000000 with sign = 1, `req_ready_o` = 0 throughout, req1's pending request is not granted, and `rsp_ready_i[1]` = 1 has no effect.
- **Undefined opcode:** opcode 4'hF with d1 = d2 = 0xFFFFFFFF -> result 0, zero 1, normal handshake.
- **Wrap-around with num_req_p = 3:** only req2 and req0 valid -> grants 0,2,0,2; `owner_q` never reaches 3.
